// File: rtl/lcd_port_ctrl.sv
// lcd_port_ctrl: HD44780 driver behind the memory-mapped LCD window (init sequence, single writes).
// Define LCD_4BIT_EN for the 4-bit bus variant (two nibble strobes per byte on lcd_db[7:4]).
module lcd_port_ctrl #(
  parameter int SETUP_CYC        = 2,
  parameter int E_PULSE_CYC      = 12,
  parameter int CMD_WAIT_CYC     = 2000,
  parameter int CLEAR_WAIT_CYC   = 82000,
  parameter int LONG_WAIT_CYC    = 205000,
  parameter int POWERUP_WAIT_CYC = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] lcd_data,
  input  logic       start,
  input  logic       go,
  output logic       fantasma,
  output logic       finish,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db
);
  localparam int MA = SETUP_CYC > E_PULSE_CYC ? SETUP_CYC : E_PULSE_CYC;
  localparam int MB = CMD_WAIT_CYC > CLEAR_WAIT_CYC ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int MC = LONG_WAIT_CYC > POWERUP_WAIT_CYC ? LONG_WAIT_CYC : POWERUP_WAIT_CYC;
  localparam int MD = MA > MB ? MA : MB;
  localparam int MAX_CYC = MC > MD ? MC : MD;
  localparam int CW = $clog2(MAX_CYC + 1);
`ifdef LCD_4BIT_EN
  localparam bit NIB = 1'b1;
  localparam logic [2:0] LAST = 3'd7;
  // {single_nibble, byte}; single nibbles travel on the high half only
  function automatic logic [8:0] entry(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: entry = {1'b1, 8'h30};
      3'd3:             entry = {1'b1, 8'h20};
      3'd4:             entry = {1'b0, 8'h28};
      3'd5:             entry = {1'b0, 8'h0C};
      3'd6:             entry = {1'b0, 8'h01};
      default:          entry = {1'b0, 8'h06};
    endcase
  endfunction
`else
  localparam bit NIB = 1'b0;
  localparam logic [2:0] LAST = 3'd6;
  function automatic logic [8:0] entry(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: entry = {1'b0, 8'h30};
      3'd3:             entry = {1'b0, 8'h38};
      3'd4:             entry = {1'b0, 8'h0C};
      3'd5:             entry = {1'b0, 8'h01};
      default:          entry = {1'b0, 8'h06};
    endcase
  endfunction
`endif
  function automatic logic [7:0] hi(input logic [7:0] b);
    hi = NIB ? {b[7:4], 4'h0} : b;
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_PWR, S_SETUP, S_PULSE, S_WAIT, S_READY} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, post;
  logic [2:0] idx, idx_n;
  logic ini, ini_n, lo, lo_n, sgl, sgl_n, ld_ent, gap;
  logic [7:0] dat, dat_n, db_n;
  logic rs_n, rw_n, e_n, fan_n, fin_n, start_q, go_q;
  logic [8:0] ent;

  wire start_edge = start & ~start_q;
  wire go_edge = go & ~go_q;
  assign ent = entry(state == S_WAIT ? idx + 3'd1 : 3'd0);
  assign gap = NIB && !lo && !sgl;
  assign post = (ini && idx == 3'd0) ? CW'(LONG_WAIT_CYC - 1) :
                (!lcd_rs && (dat == 8'h01 || dat == 8'h02)) ? CW'(CLEAR_WAIT_CYC - 1) :
                CW'(CMD_WAIT_CYC - 1);

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    ini_n = ini;
    lo_n = lo;
    sgl_n = sgl;
    dat_n = dat;
    rs_n = lcd_rs;
    rw_n = lcd_rw;
    e_n = lcd_e;
    db_n = lcd_db;
    fan_n = fantasma;
    fin_n = finish;
    ld_ent = 1'b0;
    if (start_edge) begin
      state_n = S_PWR;
      cnt_n = CW'(POWERUP_WAIT_CYC - 1);
      e_n = 1'b0;
      fan_n = 1'b0;
      fin_n = 1'b0;
    end else begin
      case (state)
        S_IDLE: state_n = S_IDLE;
        S_PWR: begin
          cnt_n = cnt - 1'b1;
          ld_ent = cnt == '0;
        end
        S_SETUP: begin
          cnt_n = cnt - 1'b1;
          if (cnt == '0) begin
            state_n = S_PULSE;
            cnt_n = CW'(E_PULSE_CYC - 1);
            e_n = 1'b1;
          end
        end
        S_PULSE: begin
          cnt_n = cnt - 1'b1;
          if (cnt == '0) begin
            state_n = S_WAIT;
            cnt_n = gap ? CW'(CMD_WAIT_CYC - 1) : post;
            e_n = 1'b0;
          end
        end
        S_WAIT: begin
          cnt_n = cnt - 1'b1;
          if (cnt == '0) begin
            if (gap) begin
              state_n = S_SETUP;
              cnt_n = CW'(SETUP_CYC - 1);
              lo_n = 1'b1;
              db_n = {dat[3:0], 4'h0};
            end else if (ini && idx != LAST) begin
              ld_ent = 1'b1;
            end else begin
              state_n = S_READY;
              fan_n = fantasma | ini;
              fin_n = finish | ~ini;
            end
          end
        end
        S_READY: if (go_edge) begin
          state_n = S_SETUP;
          cnt_n = CW'(SETUP_CYC - 1);
          ini_n = 1'b0;
          sgl_n = 1'b0;
          lo_n = 1'b0;
          dat_n = lcd_data[7:0];
          rs_n = lcd_data[9];
          rw_n = lcd_data[8];
          db_n = hi(lcd_data[7:0]);
          fin_n = 1'b0;
        end
        default: state_n = S_IDLE;
      endcase
      if (ld_ent) begin
        state_n = S_SETUP;
        cnt_n = CW'(SETUP_CYC - 1);
        ini_n = 1'b1;
        idx_n = state == S_WAIT ? idx + 3'd1 : 3'd0;
        {sgl_n, dat_n} = ent;
        lo_n = 1'b0;
        rs_n = 1'b0;
        rw_n = 1'b0;
        db_n = hi(ent[7:0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      idx <= '0;
      ini <= 1'b0;
      lo <= 1'b0;
      sgl <= 1'b0;
      dat <= '0;
      start_q <= 1'b0;
      go_q <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_rw <= 1'b0;
      lcd_e <= 1'b0;
      lcd_db <= '0;
      fantasma <= 1'b0;
      finish <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      ini <= ini_n;
      lo <= lo_n;
      sgl <= sgl_n;
      dat <= dat_n;
      start_q <= start;
      go_q <= go;
      lcd_rs <= rs_n;
      lcd_rw <= rw_n;
      lcd_e <= e_n;
      lcd_db <= db_n;
      fantasma <= fan_n;
      finish <= fin_n;
    end
  end
endmodule

// File: tb/tb_lcd_port_ctrl.sv
// tb_lcd_port_ctrl: compares lcd_port_ctrl with a timeline model of the expected LCD waveforms.
`timescale 1ns/1ps
module tb_lcd_port_ctrl;
  localparam int SU = 2, EP = 3, CMD = 5, CLR = 10, LNG = 8, PW = 20, MAXC = 4096;
`ifdef LCD_4BIT_EN
  localparam int NI = 8, NP = 12, GI = 9, PPW = 2, INIT_LEN = 149, CHR_LEN = 21, CLR_LEN = 26;
  localparam logic [7:0] INIT_B [0:NI-1] = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h28, 8'h0C, 8'h01, 8'h06};
  localparam bit INIT_S [0:NI-1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [7:0] PULSE_DB [0:NP-1] = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h20, 8'h80,
                                               8'h00, 8'hC0, 8'h00, 8'h10, 8'h00, 8'h60};
`else
  localparam int NI = 7, NP = 7, GI = 5, PPW = 1, INIT_LEN = 99, CHR_LEN = 11, CLR_LEN = 16;
  localparam logic [7:0] INIT_B [0:NI-1] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
  localparam bit INIT_S [0:NI-1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [7:0] PULSE_DB [0:NP-1] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
`endif

  logic clk = 0, rst = 1, start = 0, go = 0;
  logic [9:0] lcd_data = '0;
  logic fantasma, finish, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db;

  lcd_port_ctrl #(.SETUP_CYC(SU), .E_PULSE_CYC(EP), .CMD_WAIT_CYC(CMD), .CLEAR_WAIT_CYC(CLR),
                  .LONG_WAIT_CYC(LNG), .POWERUP_WAIT_CYC(PW)) dut (
    .clk(clk), .rst(rst), .lcd_data(lcd_data), .start(start), .go(go), .fantasma(fantasma),
    .finish(finish), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db));

  initial forever #5 clk = ~clk;

  // expected value of every output for every cycle, repainted from "now" onward on each event
  bit m_fan [MAXC], m_fin [MAXC], m_e [MAXC], m_rs [MAXC], m_rw [MAXC];
  logic [7:0] m_db [MAXC];
  int cyc = 0, ready_from = MAXC, checks = 0, errors = 0;
  int e_rise = -1, fin_rise = -1, fan_rise = -1, e_cnt = 0;
  int rq[$], wq[$];
  logic [7:0] dbq[$];
  bit ps, pg;

  task automatic check(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic hold_bus(input int t, input bit rs, input bit rw, input logic [7:0] db);
    for (int i = t; i < MAXC; i++) begin
      m_rs[i] = rs;
      m_rw[i] = rw;
      m_db[i] = db;
    end
  endtask

  task automatic pulse(input int t);
    for (int i = t; i < t + EP && i < MAXC; i++) m_e[i] = 1'b1;
  endtask

  function automatic int post(input bit rs, input logic [7:0] b, input bit lng);
    return lng ? LNG : (!rs && (b == 8'h01 || b == 8'h02)) ? CLR : CMD;
  endfunction

  task automatic send(input int t, input bit rs, input bit rw, input logic [7:0] b, input bit single,
                      input bit lng, output int done);
    int u;
    u = t;
`ifdef LCD_4BIT_EN
    hold_bus(u, rs, rw, {b[7:4], 4'h0});
    pulse(u + SU);
    if (!single) begin
      u = u + SU + EP + CMD;
      hold_bus(u, rs, rw, {b[3:0], 4'h0});
      pulse(u + SU);
    end
`else
    hold_bus(u, rs, rw, b);
    pulse(u + SU);
`endif
    done = u + SU + EP + post(rs, b, lng);
  endtask

  task automatic clear_flags(input int t);
    for (int i = t; i < MAXC; i++) begin
      m_e[i] = 1'b0;
      m_fan[i] = 1'b0;
      m_fin[i] = 1'b0;
    end
  endtask

  task automatic m_start(input int c);
    int t;
    hold_bus(c + 1, m_rs[c], m_rw[c], m_db[c]);
    clear_flags(c + 1);
    t = c + 1 + PW;
    for (int k = 0; k < NI; k++) send(t, 1'b0, 1'b0, INIT_B[k], INIT_S[k], k == 0, t);
    for (int i = t; i < MAXC; i++) m_fan[i] = 1'b1;
    ready_from = t;
  endtask

  task automatic m_write(input int c);
    int t;
    for (int i = c + 1; i < MAXC; i++) m_fin[i] = 1'b0;
    send(c + 1, lcd_data[9], lcd_data[8], lcd_data[7:0], 1'b0, 1'b0, t);
    for (int i = t; i < MAXC; i++) m_fin[i] = 1'b1;
    ready_from = t;
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) begin
      hold_bus(cyc + 1, 1'b0, 1'b0, 8'h00);
      clear_flags(cyc + 1);
      ready_from = MAXC;
      ps = 1'b0;
      pg = 1'b0;
    end else begin
      if (start && !ps) m_start(cyc);
      else if (go && !pg && cyc >= ready_from) m_write(cyc);
      ps = start;
      pg = go;
    end
    cyc++;
  end

  initial begin
    logic pe, pfin, pfan;
    pe = 0;
    pfin = 0;
    pfan = 0;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        check($sformatf("cycle%0d", cyc), {fantasma, finish, lcd_e, lcd_rs, lcd_rw, lcd_db},
              {m_fan[cyc], m_fin[cyc], m_e[cyc], m_rs[cyc], m_rw[cyc], m_db[cyc]});
        if (lcd_e && !pe) begin
          e_rise = cyc;
          e_cnt++;
          rq.push_back(cyc);
          dbq.push_back(lcd_db);
        end
        if (!lcd_e && pe) wq.push_back(cyc - e_rise);
        if (finish && !pfin) fin_rise = cyc;
        if (fantasma && !pfan) fan_rise = cyc;
        pe = lcd_e;
        pfin = finish;
        pfan = fantasma;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(input bit fan, input int after);
    for (int k = 0; k < 600 && (fan ? fan_rise : fin_rise) <= after; k++) tick(1);
  endtask

  task automatic write(input logic [9:0] d, output int n, output int k0);
    lcd_data = d;
    go = 1;
    n = cyc;
    k0 = e_cnt;
    tick(1);
    go = 0;
  endtask

  initial begin
    int n, s, k0;
    tick(3);
    rst = 0;
    tick(1);
    check("reset_outputs", {fantasma, finish, lcd_e, lcd_rs, lcd_rw, lcd_db}, 0);
    lcd_data = 10'h241;
    go = 1;
    tick(1);
    go = 0;
    tick(5);
    check("pre_start_e", e_cnt, 0);
    check("pre_start_flags", {fantasma, finish}, 0);
    // start and go rise together: only init may run
    go = 1;
    start = 1;
    s = cyc;
    tick(1);
    go = 0;
    wait_rise(1'b1, s);
    check("init_done_cycle", fan_rise - s, INIT_LEN);
    check("init_pulses", e_cnt, NP);
    check("init_finish", finish, 0);
    for (int i = 0; i < NP; i++) begin
      check($sformatf("init_db%0d", i), dbq[i], PULSE_DB[i]);
      check($sformatf("init_ewidth%0d", i), wq[i], EP);
    end
    check("clear_gap", rq[GI + 1] - rq[GI] - EP, CLR + SU);
    tick(2);
    write(10'h241, n, k0);
    wait_rise(1'b0, n);
    check("chr_finish", fin_rise - n, CHR_LEN);
    check("chr_e_start", rq[k0] - n, 3);
    check("chr_pulses", e_cnt - k0, PPW);
    check("chr_db", dbq[k0], 8'h41 & (PPW == 2 ? 8'hF0 : 8'hFF));
`ifdef LCD_4BIT_EN
    check("chr_db_lo", dbq[k0 + 1], 8'h10);
    check("chr_nib_gap", rq[k0 + 1] - rq[k0] - EP - SU, 5);
`endif
    tick(2);
    write(10'h001, n, k0);
    tick(7);
    go = 1;
    tick(1);
    go = 0;
    wait_rise(1'b0, n);
    check("clr_finish", fin_rise - n, CLR_LEN);
    check("clr_pulses", e_cnt - k0, PPW);
    tick(2);
    write(10'h248, n, k0);
    tick(2);
    check("pre_rst_e", lcd_e, 1);
    rst = 1;
    tick(1);
    check("rst_outputs", {fantasma, finish, lcd_e, lcd_rs, lcd_rw, lcd_db}, 0);
    rst = 0;
    s = cyc;
    wait_rise(1'b1, s);
    check("reinit_cycle", fan_rise - s, INIT_LEN);
    tick(2);
    write(10'h102, n, k0);
    wait_rise(1'b0, n);
    check("home_finish", fin_rise - n, CLR_LEN);
    check("home_rw", lcd_rw, 1);
    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
